// File: rtl/addsub_pkg.sv
// addsub_pkg: shared definitions for the digit-serial adder/subtractor.
//   addsub_state_t : FSM state encoding (IDLE, CALC, DONE)
//   OP_ADD/OP_SUB  : encodings of the select input
//   calc_n()       : digit cycles per operation (WIDTH/DIGIT)
package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } addsub_state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   function automatic int calc_n(input int width, input int digit);
      return width / digit;
   endfunction

endpackage

// File: rtl/addsub_digit.sv
// addsub_digit: combinational ripple-carry adder over one DIGIT-bit slice.
//   a_d, b_d : operand digits
//   cin      : carry into bit 0
//   s_d      : sum digit
//   cout     : carry out of the top bit
//   c_msb    : carry into the top bit (overflow detection on the last digit)
module addsub_digit #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a_d,
   input  logic [DIGIT-1:0] b_d,
   input  logic             cin,
   output logic [DIGIT-1:0] s_d,
   output logic             cout,
   output logic             c_msb
);

   logic [DIGIT:0] c_chain;

   assign c_chain[0] = cin;

   for (genvar i = 0; i < DIGIT; i++) begin : g_bit
      assign s_d[i]       = a_d[i] ^ b_d[i] ^ c_chain[i];
      assign c_chain[i+1] = (a_d[i] & b_d[i]) | (c_chain[i] & (a_d[i] ^ b_d[i]));
   end

   assign cout  = c_chain[DIGIT];
   assign c_msb = c_chain[DIGIT-1];

endmodule

// File: rtl/serial_adder_subtractor.sv
// serial_adder_subtractor: digit-serial two's-complement adder/subtractor.
// Processes DIGIT bits per clock, LSB digit first; N = WIDTH/DIGIT digit cycles.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start, select   : request (sampled while ready), 0 = a+b, 1 = a-b
//   a, b            : operands, captured with start
//   ready, busy     : can accept start / computation in progress
//   done            : one-cycle pulse, r/cout/ovf hold a new result
//   r, cout, ovf    : result, MSB carry-out (sub: 1 = no borrow), signed overflow
// Optional macro ADDSUB_SAT_EN: saturate r on signed overflow (direction from
// the sign of A); without it r wraps modulo 2^WIDTH.
module serial_adder_subtractor
   import addsub_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             select,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] r,
   output logic             cout,
   output logic             ovf
);

   localparam int N     = calc_n(WIDTH, DIGIT);
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   if (WIDTH % DIGIT != 0) begin : g_bad_width
      $error("serial_adder_subtractor: WIDTH must be a multiple of DIGIT");
   end

   addsub_state_t    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] opa_q, opa_d;   // A, shifted right one digit per CALC cycle
   logic [WIDTH-1:0] opb_q, opb_d;   // B (already inverted for subtract)
   logic [WIDTH-1:0] acc_q, acc_d;   // result, digits shifted in from the top
   logic [WIDTH-1:0] r_q, r_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
`ifdef ADDSUB_SAT_EN
   logic             asign_q, asign_d;
`endif

   logic [DIGIT-1:0]       dig_s;
   logic                   dig_cout;
   logic                   dig_cmsb;
   logic [WIDTH+DIGIT-1:0] acc_cat;
   logic [WIDTH-1:0]       acc_next;
   logic                   ovf_now;

   addsub_digit #(.DIGIT(DIGIT)) u_digit (
      .a_d   (opa_q[DIGIT-1:0]),
      .b_d   (opb_q[DIGIT-1:0]),
      .cin   (carry_q),
      .s_d   (dig_s),
      .cout  (dig_cout),
      .c_msb (dig_cmsb)
   );

   // Concatenate then drop the low digit: also correct for N = 1.
   assign acc_cat  = {dig_s, acc_q};
   assign acc_next = acc_cat[WIDTH+DIGIT-1:DIGIT];
   assign ovf_now  = dig_cmsb ^ dig_cout;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      acc_d   = acc_q;
      r_d     = r_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
`ifdef ADDSUB_SAT_EN
      asign_d = asign_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               opa_d   = a;
               opb_d   = b ^ {WIDTH{select}};
               carry_d = (select == OP_SUB);   // +1 completes ~b + 1
               cnt_d   = '0;
               state_d = CALC;
`ifdef ADDSUB_SAT_EN
               asign_d = a[WIDTH-1];
`endif
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            acc_d   = acc_next;
            opa_d   = opa_q >> DIGIT;
            opb_d   = opb_q >> DIGIT;
            carry_d = dig_cout;
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               state_d = DONE;
               cout_d  = dig_cout;
               ovf_d   = ovf_now;
`ifdef ADDSUB_SAT_EN
               if (ovf_now)
                  r_d = asign_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
               else
                  r_d = acc_next;
`else
               r_d = acc_next;
`endif
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         opa_q   <= '0;
         opb_q   <= '0;
         acc_q   <= '0;
         r_q     <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
`ifdef ADDSUB_SAT_EN
         asign_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         acc_q   <= acc_d;
         r_q     <= r_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
`ifdef ADDSUB_SAT_EN
         asign_q <= asign_d;
`endif
      end
   end

   assign busy  = (state_q == CALC);
   assign ready = ~busy;
   assign done  = (state_q == DONE);
   assign r     = r_q;
   assign cout  = cout_q;
   assign ovf   = ovf_q;

endmodule
